// File: rtl/cic_ctrl_pkg.sv
// Shared types and default constants for the CIC acquisition sequencer.
// Holds the sequencer state encoding and an index-width helper.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWarm,
        StRun,
        StStop
    } seq_state_e;

    localparam int unsigned DefCh     = 8;
    localparam int unsigned DefW      = 16;
    localparam int unsigned DefDiv    = 4;
    localparam int unsigned DefR      = 64;
    localparam int unsigned DefWarmup = 3;

    // Width of a counter/index spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cic_sequencer_if.sv
// Output sample stream of the CIC sequencer: one channel word per valid/ready beat.
interface cic_sequencer_if
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned CH = DefCh,
    parameter int unsigned W  = DefW
) ();

    localparam int unsigned CW = idx_width(CH);

    logic [W-1:0]  out_data;
    logic [CW-1:0] out_ch;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/pdm_clkgen.sv
// PDM bit clock divider plus integrator (pdm_en) and decimation (dec_stb) strobes.
// Counters sit at zero while run is low.
module pdm_clkgen
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DefDiv,
    parameter int unsigned R   = DefR
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic pdm_clk,
    output logic pdm_en,
    output logic dec_stb
);

    localparam int unsigned DW = idx_width(DIV);
    localparam int unsigned BW = idx_width(R);

    logic [DW-1:0] d_q, d_d;
    logic [BW-1:0] b_q, b_d;
    logic          d_wrap, b_wrap;

    always_comb begin
        d_wrap = (d_q == DW'(DIV - 1));
        b_wrap = (b_q == BW'(R - 1));
        d_d    = d_q;
        b_d    = b_q;
        if (!run) begin
            d_d = '0;
            b_d = '0;
        end else begin
            d_d = d_wrap ? '0 : d_q + DW'(1);
            if (d_wrap) begin
                b_d = b_wrap ? '0 : b_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
            b_q <= '0;
        end else begin
            d_q <= d_d;
            b_q <= b_d;
        end
    end

    assign pdm_clk = run && (d_q < DW'(DIV / 2));
    assign pdm_en  = run && d_wrap;
    assign dec_stb = pdm_en && b_wrap;

endmodule

// File: rtl/cic_sequencer.sv
// Sequences CH microphone CIC channels: warm-up, per-frame snapshot of all CIC
// outputs, and streaming of the snapshot one channel per handshake.
module cic_sequencer
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned CH     = DefCh,
    parameter int unsigned W      = DefW,
    parameter int unsigned DIV    = DefDiv,
    parameter int unsigned R      = DefR,
    parameter int unsigned WARMUP = DefWarmup
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                pdm_clk,
    output logic                pdm_en,
    output logic                dec_stb,
    output logic                cic_rst,
    input  logic [CH*W-1:0]     ch_data,
    cic_sequencer_if.master     strm,
    output logic                overrun,
    output logic                busy
);

    localparam int unsigned CW  = idx_width(CH);
    localparam int unsigned WCW = idx_width(WARMUP);

    seq_state_e     state_q, state_d;
    logic [WCW-1:0] warm_q, warm_d;
    logic           cap_q, cap_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [W-1:0]   snap_q [CH];
    logic [W-1:0]   snap_d [CH];
    logic           ovr_q, ovr_d;
    logic           run, streaming, beat_done;

    assign run = (state_q != StIdle);

    pdm_clkgen #(
        .DIV (DIV),
        .R   (R)
    ) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .pdm_clk (pdm_clk),
        .pdm_en  (pdm_en),
        .dec_stb (dec_stb)
    );

    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        cap_d     = 1'b0;
        valid_d   = valid_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        ovr_d     = ovr_q;
        // A frame occupies the sequencer from the strobe until its last beat.
        streaming = cap_q || valid_q;
        beat_done = valid_q && strm.out_ready;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWarm;
                    ovr_d   = 1'b0;
                end
            end
            StWarm: begin
                if (!enable) begin
                    state_d = StIdle;
                    warm_d  = '0;
                end else if (dec_stb) begin
                    if (warm_q == WCW'(WARMUP - 1)) begin
                        warm_d  = '0;
                        state_d = StRun;
                    end else begin
                        warm_d = warm_q + WCW'(1);
                    end
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StStop;
                end else if (dec_stb) begin
                    if (streaming) begin
                        ovr_d = 1'b1;
                    end else begin
                        cap_d = 1'b1;
                    end
                end
            end
            StStop: begin
                if (!streaming) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Sample one cycle after the strobe so the comb stage has settled.
        if (cap_q) begin
            for (int k = 0; k < CH; k++) begin
                snap_d[k] = ch_data[k*W +: W];
            end
            valid_d = 1'b1;
            idx_d   = '0;
        end

        if (beat_done) begin
            if (idx_q == CW'(CH - 1)) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            warm_q  <= '0;
            cap_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end

    assign cic_rst        = (state_q == StIdle);
    assign busy           = run;
    assign overrun        = ovr_q;
    assign strm.out_valid = valid_q;
    assign strm.out_ch    = idx_q;
    assign strm.out_last  = valid_q && (idx_q == CW'(CH - 1));
    assign strm.out_data  = snap_q[idx_q];

endmodule

// File: tb/tb_cic_sequencer.sv
// Scoreboard bench for cic_sequencer: strobe model, warm-up, streaming,
// backpressure, overrun, stop and mid-frame reset.
module tb_cic_sequencer;

    localparam int unsigned CH     = 8;
    localparam int unsigned W      = 16;
    localparam int unsigned DIV    = 4;
    localparam int unsigned R      = 8;
    localparam int unsigned WARMUP = 3;
    localparam int          PER    = DIV * R;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   ch;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          pdm_clk, pdm_en, dec_stb, cic_rst, overrun, busy;
    logic [CH*W-1:0] ch_data;

    cic_sequencer_if #(.CH(CH), .W(W)) strm ();

    cic_sequencer #(
        .CH     (CH),
        .W      (W),
        .DIV    (DIV),
        .R      (R),
        .WARMUP (WARMUP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .pdm_clk (pdm_clk),
        .pdm_en  (pdm_en),
        .dec_stb (dec_stb),
        .cic_rst (cic_rst),
        .ch_data (ch_data),
        .strm    (strm),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb_q[$];
    bit    model_on = 0;
    int    c = 0;
    int    nstb = 0;
    bit    exp_ovr = 0;
    int    fr_idx = 0;
    int    first_valid_c = -1;
    int    stall_cnt = 0;
    bit    stall_bp = 0, stall_ovr = 0, stall_mid = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pdm_clk"}, pdm_clk, 0);
        check_eq({tag, "_pdm_en"}, pdm_en, 0);
        check_eq({tag, "_dec_stb"}, dec_stb, 0);
        check_eq({tag, "_cic_rst"}, cic_rst, 1);
        check_eq({tag, "_valid"}, strm.out_valid, 0);
        check_eq({tag, "_last"}, strm.out_last, 0);
        check_eq({tag, "_ch"}, strm.out_ch, 0);
        check_eq({tag, "_data"}, strm.out_data, 0);
        check_eq({tag, "_overrun"}, overrun, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // One cycle: sample at negedge, check strobes, drive data/ready, score beats.
    task automatic tick();
        int  c_now;
        int  base;
        bit  rdy;
        @(negedge clk);
        c_now = c;
        if (model_on) begin
            check_eq("overrun", overrun, exp_ovr);
            check_eq("busy_on", busy, 1);
            check_eq("cic_rst_on", cic_rst, 0);
            check_eq("pdm_clk", pdm_clk, (c % DIV) < (DIV / 2));
            check_eq("pdm_en", pdm_en, (c % DIV) == (DIV - 1));
            check_eq("dec_stb", dec_stb, (c % PER) == (PER - 1));
            if ((c % PER) == (PER - 1)) begin
                nstb++;
                base = 32'h1000 + 32'h100 * (nstb - 4);
                for (int k = 0; k < CH; k++) begin
                    ch_data[k*W +: W] = W'(base + k);
                end
                if (nstb > WARMUP) begin
                    if (sb_q.size() == 0) begin
                        for (int k = 0; k < CH; k++) begin
                            sb_q.push_back('{data: W'(base + k), ch: 3'(k), last: (k == CH - 1)});
                        end
                    end else begin
                        exp_ovr = 1;
                    end
                end
            end
            c++;
        end

        rdy = 1;
        if (stall_bp && fr_idx == 0 && strm.out_valid && strm.out_ch == 3 && stall_cnt < 5) begin
            rdy = 0;
            stall_cnt++;
        end
        if (stall_ovr && fr_idx == 1 && c_now < 200) rdy = 0;
        if (stall_mid && sb_q.size() > 0 && sb_q.size() <= 4) rdy = 0;
        strm.out_ready = rdy;

        if (strm.out_valid) begin
            if (first_valid_c < 0) first_valid_c = c_now;
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", strm.out_valid, 0);
            end else begin
                check_eq("out_data", strm.out_data, sb_q[0].data);
                check_eq("out_ch", strm.out_ch, sb_q[0].ch);
                check_eq("out_last", strm.out_last, sb_q[0].last);
                if (rdy) begin
                    if (sb_q[0].last) fr_idx++;
                    void'(sb_q.pop_front());
                end
            end
        end
    endtask

    task automatic start_run();
        enable        = 1;
        model_on      = 1;
        c             = 0;
        nstb          = 0;
        exp_ovr       = 0;
        fr_idx        = 0;
        first_valid_c = -1;
        stall_cnt     = 0;
        stall_bp      = 0;
        stall_ovr     = 0;
        stall_mid     = 0;
    endtask

    initial begin
        rst            = 1;
        enable         = 0;
        ch_data        = '0;
        strm.out_ready = 1;
        repeat (3) @(posedge clk);
        tick();
        check_reset_vals("reset");
        rst = 0;
        tick();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_pdm_clk", pdm_clk, 0);

        // Enable dropped during warm-up returns straight to idle.
        start_run();
        repeat (10) tick();
        enable   = 0;
        model_on = 0;
        tick();
        check_eq("warm_abort_busy", busy, 0);
        check_eq("warm_abort_cic_rst", cic_rst, 1);

        // Run 1: backpressure on frame 0, overrun on frame 1, stop during frame 2.
        start_run();
        stall_bp  = 1;
        stall_ovr = 1;
        for (int i = 0; i < 400 && !(fr_idx == 2 && sb_q.size() == 5); i++) tick();
        check_eq("run1_reach_stop_point", (fr_idx == 2 && sb_q.size() == 5), 1);
        check_eq("run1_first_valid", first_valid_c, 4 * PER - 1 + 2);
        check_eq("run1_overrun", overrun, 1);
        enable   = 0;
        model_on = 0;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        check_eq("stop_drain_left", sb_q.size(), 0);
        tick();
        check_eq("stop_busy", busy, 1);
        tick();
        check_eq("stop_idle_busy", busy, 0);
        check_eq("stop_idle_valid", strm.out_valid, 0);
        check_eq("stop_idle_cic_rst", cic_rst, 1);
        check_eq("stop_idle_pdm_clk", pdm_clk, 0);
        check_eq("overrun_sticky", overrun, 1);

        // Run 2: overrun clears on restart; reset lands mid-frame.
        start_run();
        stall_mid = 1;
        for (int i = 0; i < 300 && !(sb_q.size() == 4 && strm.out_valid); i++) tick();
        check_eq("run2_mid_frame", (sb_q.size() == 4 && strm.out_valid), 1);
        repeat (2) tick();
        check_eq("run2_first_valid", first_valid_c, 4 * PER - 1 + 2);
        rst      = 1;
        model_on = 0;
        sb_q.delete();
        tick();
        check_reset_vals("midrst");
        enable = 0;
        tick();
        rst = 0;
        repeat (5) tick();
        check_eq("post_rst_valid", strm.out_valid, 0);
        check_eq("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_sequencer.md
CIC_SEQUENCER -- requirements
Module: cic_sequencer

Interface
REQ-001 SHALL have parameter CH, default 8: number of microphone CIC channels sequenced.
REQ-002 SHALL have parameter W, default 16: width of each CIC output word.
REQ-003 SHALL have parameter DIV, default 4, even and >= 2: clk cycles per PDM bit period.
REQ-004 SHALL have parameter R, default 64: PDM bits per decimated output.
REQ-005 SHALL have parameter WARMUP, default 3: decimated outputs discarded after start, covering CIC settling.
REQ-006 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port enable, input, 1: level; high requests acquisition.
REQ-009 SHALL have port pdm_clk, output, 1: microphone bit clock.
REQ-010 SHALL have port pdm_en, output, 1: one-cycle strobe marking each PDM bit, used as the CIC integrator enable.
REQ-011 SHALL have port dec_stb, output, 1: one-cycle strobe marking each decimated output, used as the CIC comb enable.
REQ-012 SHALL have port cic_rst, output, 1: holds all CIC channels cleared.
REQ-013 SHALL have port ch_data, input, CH*W: packed CIC outputs; channel k occupies bits [k*W +: W].
REQ-014 SHALL have port out_data, output, W: streamed sample.
REQ-015 SHALL have port out_ch, output, clog2(CH): channel index of out_data.
REQ-016 SHALL have port out_last, output, 1: high with channel CH-1.
REQ-017 SHALL have port out_valid, output, 1: stream valid.
REQ-018 SHALL have port out_ready, input, 1: stream ready.
REQ-019 SHALL have port overrun, output, 1: sticky flag; a frame was dropped.
REQ-020 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-021 SHALL implement states IDLE, WARM, RUN and STOP.
REQ-022 SHALL, in IDLE, hold the divider counter at 0, drive pdm_clk=0 and cic_rst=1, and keep pdm_en, dec_stb and out_valid at 0.
REQ-023 SHALL make the transition IDLE->WARM on enable=1, clear overrun on the same cycle, and set cic_rst=0 from the next cycle.
REQ-024 SHALL run, outside IDLE, a divider counter d cycling 0..DIV-1 with pdm_clk=1 for d<DIV/2 and pdm_en=1 when d=DIV-1.
REQ-025 SHALL count pdm_en pulses in a counter b cycling 0..R-1 and assert dec_stb coincident with the pdm_en that wraps b from R-1 to 0, giving one dec_stb per DIV*R clk cycles.
REQ-026 SHALL, in WARM, count dec_stb pulses and move to RUN on the WARMUP-th pulse; that pulse's frame is not captured.
REQ-027 SHALL, in RUN on dec_stb with no frame streaming, latch all of ch_data into a snapshot buffer one cycle after dec_stb, so that CIC comb outputs have updated.
REQ-028 SHALL assert out_valid two cycles after dec_stb, presenting channels 0..CH-1 in order, with out_ch equal to the channel index.
REQ-029 SHALL advance one channel per cycle in which out_valid and out_ready are both 1, and hold out_data, out_ch and out_last stable while out_valid=1 and out_ready=0.
REQ-030 SHALL deassert out_valid after the channel CH-1 handshake.
REQ-031 SHALL, on a dec_stb arriving while a frame is still streaming, leave the snapshot unchanged, drop the new frame and set overrun=1.
REQ-032 SHALL, on enable=0 in WARM, return to IDLE on the next cycle.
REQ-033 SHALL, on enable=0 in RUN, go to STOP: no new capture, the current frame finishes, then IDLE. If no frame is streaming, STOP lasts one cycle.
REQ-034 SHALL let enable=1 in STOP have no effect; re-start happens only from IDLE.
REQ-035 SHALL make busy=0 only in IDLE.

Reset
REQ-036 SHALL, on rst=1, from any state including mid-frame, enter IDLE on the next edge with pdm_clk=0, pdm_en=0, dec_stb=0, cic_rst=1, out_valid=0, out_last=0, out_ch=0, out_data=0, overrun=0, busy=0, all counters 0, and discard any partial frame.

Structure
REQ-037 SHALL place the state enumeration and the default parameter constants in the shared package cic_ctrl_pkg.
REQ-038 SHALL place the divider, the bit counter and the strobe generation in the sub-module pdm_clkgen, with inputs clk, rst, run and outputs pdm_clk, pdm_en, dec_stb.

Verification
REQ-039 SHALL cover strobe timing: DIV=4, R=8, enable held high -> pdm_clk period 4 cycles, high 2; pdm_en every 4 cycles; dec_stb every 32 cycles, aligned to a pdm_en.
REQ-040 SHALL cover warm-up: WARMUP=3 -> no out_valid before the 4th dec_stb; first valid frame exactly 2 cycles after the 4th dec_stb.
REQ-041 SHALL cover streaming: CH=8, out_ready=1, channel k driven with 0x1000+k -> 8 consecutive beats 0x1000..0x1007 with out_ch 0..7 and out_last on beat 7.
REQ-042 SHALL cover backpressure: out_ready=0 for 5 cycles at beat 3 -> beat 3 held stable, then delivered; no loss, no duplicate.
REQ-043 SHALL cover overrun: out_ready=0 across a dec_stb -> overrun=1, snapshot unchanged; next enable rise -> overrun=0.
REQ-044 SHALL cover stop and reset: enable=0 mid-frame -> remaining beats complete, then busy=0; rst mid-frame -> all outputs at reset values next cycle.
